// File: rtl/bsg_and_arb_pkg.sv
// Shared helpers for the bsg_and_arb slice.
// Holds the derivation of the requester-id width so the top and the picker agree.
package bsg_and_arb_pkg;

   // Requester id width: max(1, clog2(els)), so a single requester still gets a 1-bit id
   function automatic int lg_els_f(input int els);
      return (els <= 2) ? 1 : $clog2(els);
   endfunction

endpackage

// File: rtl/bsg_and.sv
// Plain bitwise-AND datapath, shared by the arbiter.
module bsg_and #(
   parameter int width_p = 64
) (
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   output logic [width_p-1:0] o
);

   // Bitwise AND of the two operands
   always_comb begin
      o = a_i & b_i;
   end

endmodule

// File: rtl/bsg_and_arb_rr.sv
// Combinational round-robin picker: the first requester after last_i (wrapping)
// wins. Reusable by any arbiter that keeps its own last-grant register.
module bsg_and_arb_rr
   import bsg_and_arb_pkg::*;
#(
   parameter  int els_p     = 4,
   localparam int lg_els_lp = lg_els_f(els_p)
) (
   input  logic [els_p-1:0]     req_i,
   input  logic [lg_els_lp-1:0] last_i,
   output logic [els_p-1:0]     grant_o,
   output logic [lg_els_lp-1:0] id_o,
   output logic                 any_o
);

   // Walk offsets 1..els_p from the last winner and take the first live request
   always_comb begin
      int idx;
      idx     = 0;
      grant_o = '0;
      id_o    = '0;
      any_o   = 1'b0;
      for (int k = 1; k <= els_p; k++) begin
         idx = int'(last_i) + k;
         if (idx >= els_p) begin
            idx = idx - els_p;
         end
         for (int i = 0; i < els_p; i++) begin
            if (!any_o && (i == idx) && req_i[i]) begin
               grant_o[i] = 1'b1;
               id_o       = lg_els_lp'(i);
               any_o      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bsg_and_arb.sv
// Round-robin shared AND unit: els_p requesters feed one bsg_and through a
// valid/ready handshake; the result sits in a single-entry slot drained by yumi_i.
// Optional owner lock is enabled by defining BSG_AND_ARB_LOCK_EN (adds lock_i).
module bsg_and_arb
   import bsg_and_arb_pkg::*;
#(
   parameter  int width_p   = 64,
   parameter  int els_p     = 4,
   localparam int lg_els_lp = lg_els_f(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [els_p-1:0]         v_i,
   input  logic [els_p*width_p-1:0] a_i,
   input  logic [els_p*width_p-1:0] b_i,
   output logic [els_p-1:0]         ready_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   output logic [lg_els_lp-1:0]     id_o,
   input  logic                     yumi_i
`ifdef BSG_AND_ARB_LOCK_EN
  ,input  logic [els_p-1:0]         lock_i
`endif
);

   logic                 v_q, v_d;
   logic [width_p-1:0]   data_q, data_d;
   logic [lg_els_lp-1:0] id_q, id_d;
   logic [lg_els_lp-1:0] last_q, last_d;

   logic [els_p-1:0]     req;
   logic [els_p-1:0]     grant;
   logic [lg_els_lp-1:0] gnt_id;
   logic                 any_grant;
   logic                 slot_free;
   logic                 accept;
   logic [width_p-1:0]   a_sel, b_sel, and_out;

`ifdef BSG_AND_ARB_LOCK_EN
   logic                 lock_q, lock_d;
   logic [lg_els_lp-1:0] owner_q, owner_d;
   logic [els_p-1:0]     owner_mask;

   // While locked only the owner may compete, even if it is idle
   always_comb begin
      for (int i = 0; i < els_p; i++) begin
         owner_mask[i] = (owner_q == lg_els_lp'(i));
      end
      req = lock_q ? (v_i & owner_mask) : v_i;
   end

   // An accepted beat's lock bit decides whether its sender keeps the unit
   always_comb begin
      lock_d  = lock_q;
      owner_d = owner_q;
      if (accept) begin
         lock_d  = |(lock_i & grant);
         owner_d = gnt_id;
      end
   end

   // Lock state, cleared by reset
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         lock_q  <= 1'b0;
         owner_q <= '0;
      end else begin
         lock_q  <= lock_d;
         owner_q <= owner_d;
      end
   end
`else
   // Pure round-robin: every valid requester competes
   always_comb begin
      req = v_i;
   end
`endif

   bsg_and_arb_rr #(
      .els_p (els_p)
   ) rr (
      .req_i   (req),
      .last_i  (last_q),
      .grant_o (grant),
      .id_o    (gnt_id),
      .any_o   (any_grant)
   );

   // One-hot AND-OR mux of the winner's operands into the shared datapath
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < els_p; i++) begin
         if (grant[i]) begin
            a_sel = a_sel | a_i[i*width_p +: width_p];
            b_sel = b_sel | b_i[i*width_p +: width_p];
         end
      end
   end

   bsg_and #(
      .width_p (width_p)
   ) dp (
      .a_i (a_sel),
      .b_i (b_sel),
      .o   (and_out)
   );

   // Handshake: the slot can take a beat when empty or being drained this cycle
   always_comb begin
      slot_free = ~v_q | yumi_i;
      accept    = any_grant & slot_free;
      ready_o   = grant & {els_p{slot_free}};
   end

   // Next-state for the result slot and the round-robin pointer
   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      id_d   = id_q;
      last_d = last_q;
      if (accept) begin
         v_d    = 1'b1;
         data_d = and_out;
         id_d   = gnt_id;
         last_d = gnt_id;
      end else if (yumi_i) begin
         v_d    = 1'b0;
      end
   end

   // Result slot and pointer; last resets to els_p-1 so requester 0 goes first
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_q    <= 1'b0;
         data_q <= '0;
         id_q   <= '0;
         last_q <= lg_els_lp'(els_p - 1);
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
         id_q   <= id_d;
         last_q <= last_d;
      end
   end

   assign v_o    = v_q;
   assign data_o = data_q;
   assign id_o   = id_q;

`ifndef SYNTHESIS
   // The consumer may only take a result that is actually present
   yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_q);
`endif

endmodule

// File: tb/tb_bsg_and_arb.sv
// Bench for bsg_and_arb (els_p=4, width_p=64): directed steps plus random
// traffic checked against a behavioural model of the arbiter and result slot.
// Define BSG_AND_ARB_LOCK_EN to also exercise the owner lock.
module tb_bsg_and_arb;
   import bsg_and_arb_pkg::*;

   localparam int width_p   = 64;
   localparam int els_p     = 4;
   localparam int lg_els_lp = lg_els_f(els_p);

   logic                     clk_i = 1'b0;
   logic                     reset_n_i;
   logic [els_p-1:0]         v_i;
   logic [els_p*width_p-1:0] a_i, b_i;
   logic [els_p-1:0]         ready_o;
   logic                     v_o;
   logic [width_p-1:0]       data_o;
   logic [lg_els_lp-1:0]     id_o;
   logic                     yumi_i;
`ifdef BSG_AND_ARB_LOCK_EN
   logic [els_p-1:0]         lock_i;
`endif

   int checks = 0;
   int passed = 0;
   int failed = 0;

   // Model state: result slot contents and round-robin pointer
   bit                 m_v;
   logic [width_p-1:0] m_data;
   int                 m_id;
   int                 m_last;
   bit                 m_lock;
   int                 m_owner;

   always #5 clk_i = ~clk_i;

   bsg_and_arb #(
      .width_p (width_p),
      .els_p   (els_p)
   ) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (v_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .ready_o   (ready_o),
      .v_o       (v_o),
      .data_o    (data_o),
      .id_o      (id_o),
      .yumi_i    (yumi_i)
`ifdef BSG_AND_ARB_LOCK_EN
     ,.lock_i    (lock_i)
`endif
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit vBit(input int i);
      return v_i[lg_els_lp'(i)];
   endfunction

   // Who the arbiter should pick now, or -1 when nothing transfers
   function automatic int modelGrant();
      if (m_v && !yumi_i) return -1;
      if (m_lock) return vBit(m_owner) ? m_owner : -1;
      for (int k = 1; k <= els_p; k++) begin
         if (vBit((m_last + k) % els_p)) return (m_last + k) % els_p;
      end
      return -1;
   endfunction

   task automatic modelReset();
      m_v     = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_last  = els_p - 1;
      m_lock  = 1'b0;
      m_owner = 0;
   endtask

   task automatic modelUpdate(input int g);
      if (g >= 0) begin
         m_v    = 1'b1;
         m_data = width_p'(a_i >> (g * width_p)) & width_p'(b_i >> (g * width_p));
         m_id   = g;
         m_last = g;
`ifdef BSG_AND_ARB_LOCK_EN
         m_lock = lock_i[lg_els_lp'(g)];
         if (m_lock) m_owner = g;
`endif
      end else if (yumi_i) begin
         m_v = 1'b0;
      end
   endtask

   // Drive requests with fresh random operands; yumi only while a result exists
   task automatic applyStimulus(input logic [els_p-1:0] v, input bit yumi_req);
      v_i = v;
      for (int i = 0; i < els_p; i++) begin
         a_i[i*width_p +: width_p] = {$urandom(), $urandom()};
         b_i[i*width_p +: width_p] = {$urandom(), $urandom()};
      end
      yumi_i = yumi_req & v_o;
   endtask

   // Check outputs mid-cycle, then advance the model across the clock edge
   task automatic stepCycle(input string tag, output int g);
      logic [els_p-1:0] exp_ready;
      @(negedge clk_i);
      g = modelGrant();
      exp_ready = (g >= 0) ? (els_p'(1) << g) : '0;
      checkOutput({tag, "_ready"}, 64'(ready_o), 64'(exp_ready));
      checkOutput({tag, "_v"}, 64'(v_o), 64'(m_v));
      checkOutput({tag, "_data"}, data_o, m_data);
      checkOutput({tag, "_id"}, 64'(id_o), 64'(m_id));
      @(posedge clk_i);
      modelUpdate(g);
      #1;
   endtask

   // Asynchronous reset: outputs must clear before any clock edge
   task automatic doReset(input string tag);
      reset_n_i = 1'b0;
      v_i       = '0;
      yumi_i    = 1'b0;
`ifdef BSG_AND_ARB_LOCK_EN
      lock_i    = '0;
`endif
      #1;
      modelReset();
      checkOutput({tag, "_v"}, 64'(v_o), 64'd0);
      checkOutput({tag, "_data"}, data_o, 64'd0);
      checkOutput({tag, "_id"}, 64'(id_o), 64'd0);
      checkOutput({tag, "_ready"}, 64'(ready_o), 64'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int g;
      int rr_exp[6];
      logic [width_p-1:0] held_data;
      int held_id;

      reset_n_i = 1'b0;
      v_i = '0;
      a_i = '0;
      b_i = '0;
      yumi_i = 1'b0;
`ifdef BSG_AND_ARB_LOCK_EN
      lock_i = '0;
`endif
      #2;
      doReset("rst0");

      // Idle after reset
      for (int c = 0; c < 5; c++) begin
         applyStimulus('0, 1'b0);
         stepCycle("idle", g);
      end

      // Single requester 2 with known operands
      applyStimulus(4'b0100, 1'b1);
      a_i[2*width_p +: width_p] = 64'hFFFF_0000_FFFF_0000;
      b_i[2*width_p +: width_p] = 64'h0F0F_0F0F_0F0F_0F0F;
      #1;
      checkOutput("single_ready", 64'(ready_o), 64'h4);
      stepCycle("single", g);
      checkOutput("single_data_known", data_o, 64'h0F0F_0000_0F0F_0000);
      checkOutput("single_id_known", 64'(id_o), 64'd2);
      applyStimulus('0, 1'b1);
      stepCycle("drain", g);

      // All four continuously valid from a fresh pointer
      doReset("rst1");
      rr_exp = '{0, 1, 2, 3, 0, 1};
      for (int c = 0; c < 6; c++) begin
         applyStimulus(4'b1111, 1'b1);
         stepCycle("rr", g);
         checkOutput("rr_seq", 64'(g), 64'(rr_exp[c]));
      end

      // Backpressure: slot full, no yumi
      held_data = data_o;
      held_id   = m_id;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(4'b1111, 1'b0);
         stepCycle("bp", g);
         checkOutput("bp_hold", data_o, held_data);
      end
      applyStimulus(4'b1111, 1'b1);
      stepCycle("bp_release", g);
      checkOutput("bp_next", 64'(g), 64'((held_id + 1) % els_p));

      // Random traffic against the model
      for (int c = 0; c < 300; c++) begin
         applyStimulus(els_p'($urandom), $urandom_range(0, 3) != 0);
`ifdef BSG_AND_ARB_LOCK_EN
         lock_i = ($urandom_range(0, 3) == 0) ? els_p'($urandom) : '0;
`endif
         stepCycle("rand", g);
      end

      // Asynchronous reset while a result is held
`ifdef BSG_AND_ARB_LOCK_EN
      lock_i = '0;
`endif
      applyStimulus(4'b1111, 1'b1);
      stepCycle("pre_rst", g);
      checkOutput("pre_rst_vo", 64'(v_o), 64'd1);
      doReset("mid_rst");
      applyStimulus(4'b1111, 1'b1);
      stepCycle("post_rst", g);
      checkOutput("post_rst_first", 64'(g), 64'd0);
      stepCycle("post_rst2", g);

`ifdef BSG_AND_ARB_LOCK_EN
      // Requester 1 locks for three beats while 0 and 3 wait
      begin
         int ids[$];
         int cnt1;
         doReset("rst_lock");
         applyStimulus(4'b0001, 1'b1);
         stepCycle("lock_pre", g);
         cnt1 = 0;
         for (int c = 0; c < 20 && ids.size() < 5; c++) begin
            applyStimulus({1'b1, 1'b0, cnt1 < 3, 1'b1}, 1'b1);
            lock_i = {2'b00, cnt1 < 2, 1'b0};
            stepCycle("lock", g);
            if (g >= 0) ids.push_back(g);
            if (g == 1) cnt1++;
         end
         checkOutput("lock_count", 64'(ids.size()), 64'd5);
         rr_exp[0:4] = '{1, 1, 1, 3, 0};
         for (int i = 0; i < 5 && i < ids.size(); i++) begin
            checkOutput("lock_seq", 64'(ids[i]), 64'(rr_exp[i]));
         end
      end
`endif

      applyStimulus('0, 1'b0);
      stepCycle("final", g);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/bsg_and_arb.md
Name: bsg_and_arb

Overview:
- Shares one width_p-bit bitwise-AND datapath (bsg_and instance) among els_p requesters.
- Round-robin arbitration with a valid/ready input handshake per requester.
- Result is registered in a single-entry output stage, tagged with the winner's index, and drained with valid/yumi.
- Sits between several operand producers (e.g. mask generators) and one consumer of masked words.

Parameters:
- width_p, 64, operand/result width in bits.
- els_p, 4, number of requesters (>=1).
- lg_els_lp, max(1, clog2(els_p)), derived width of the requester id; not user-set.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  reset, asynchronous assert, active-low; release synchronised externally.
- v_i  in  els_p  per-requester operand valid.
- a_i  in  els_p*width_p  operand A; requester i occupies bits [i*width_p +: width_p].
- b_i  in  els_p*width_p  operand B, same packing.
- ready_o  out  els_p  per-requester accept; a beat transfers when v_i[i] & ready_o[i].
- v_o  out  1  result valid.
- data_o  out  width_p  registered a&b of the accepted beat.
- id_o  out  lg_els_lp  index of the requester that produced data_o.
- yumi_i  in  1  consumer takes the result this cycle; legal only while v_o=1.

Behaviour:
- Reset (reset_n_i=0, takes effect immediately):
  - v_o=0, data_o=0, id_o=0.
  - last-grant pointer = els_p-1, so requester 0 has first priority.
  - Any held result is discarded.
- Output slot free = ~v_o | yumi_i.
- Grant (combinational): the first i with v_i[i]=1, searching from last+1 modulo els_p upward.
- ready_o[i] = grant[i] & slot free.
  - At most one ready_o bit is high per cycle.
  - A ready_o bit is never high without its v_i bit.
  - ready_o depends combinationally on v_i and yumi_i, so requesters must not derive v_i from ready_o.
- On accept of requester g (clock edge):
  - data_o <= a_g & b_g.
  - id_o <= g.
  - v_o <= 1.
  - last <= g.
- yumi_i with no new accept: v_o <= 0; data_o and id_o hold their values.
- Simultaneous yumi_i and accept: the slot is refilled in the same cycle, giving 1 result/cycle sustained throughput.
- Latency: 1 cycle from accept to v_o.
- When the slot is full and yumi_i=0:
  - All ready_o = 0.
  - Outputs hold stable.
  - last does not move.
- No requester valid: last holds.
- els_p=1: the grant is always requester 0, and id_o is a 1-bit constant 0.
- yumi_i while v_o=0 is a protocol error: simulation assertion fires; the RTL ignores it.
- Fairness: a continuously valid requester is granted within els_p accepts.

Optional Feature:
- Macro: BSG_AND_ARB_LOCK_EN.
- Defined:
  - Adds input port lock_i, width els_p.
  - An accepted beat with lock_i[g]=1 sets lock_r and owner_r=g.
  - While lock_r=1, the grant is forced to owner_r. Other requesters see ready_o=0 even if owner_r is idle.
  - An accepted owner beat with lock_i[g]=0 clears lock_r, and that beat is still transferred.
  - Reset clears lock_r.
  - last updates as normal, so round-robin resumes after owner_r.
- Undefined: no lock_i port, no lock state; pure round-robin as above.

Decomposition:
- Package bsg_and_arb_pkg holds:
  - The localparam function for lg_els_lp, i.e. max(1, clog2(els_p)).
  - No typedefs beyond that.
- One sub-module: bsg_and_arb_rr (els_p). It is a combinational round-robin picker.
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant, encoded id, any_grant.
  - It is reusable by other arbiters.
- The datapath reuses the existing bsg_and (width_p) on the muxed operands. The output register lives in bsg_and_arb.

Test Plan:
- Reset then release, v_i=0: v_o=0, data_o=0, id_o=0, ready_o=0 for 5 cycles.
- Single requester 2 with a=0xFFFF_0000_FFFF_0000 and b=0x0F0F_0F0F_0F0F_0F0F, yumi_i tied 1:
  - ready_o=4'b0100.
  - Next cycle v_o=1, data_o=0x0F0F_0000_0F0F_0000, id_o=2.
- All four requesters valid continuously, yumi_i=1: id_o sequence 0,1,2,3,0,1 with one result per cycle.
- Backpressure: slot full and yumi_i=0 for 3 cycles.
  - ready_o=0 and data_o stable throughout.
  - With yumi_i=1, the next accept is the next requester after the held id.
- Assert reset_n_i=0 mid-stream while v_o=1: v_o drops immediately without a clock edge. After release, requester 0 wins first.
- LOCK_EN build:
  - Requester 1 sends 3 beats with lock=1,1,0 while requesters 0 and 3 are valid.
  - id_o sequence is 1,1,1, then 3, then 0.
